// File: rtl/phys_reg_free_list.sv
// Physical-register free list: a free bitmap plus a registered free counter.
// Hands up to two lowest-index free registers to rename and absorbs ROB release masks.
module phys_reg_free_list #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned PREG_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_req_1,
  input  logic                 alloc_req_2,
  output logic [PREG_W-1:0]    alloc_preg_1,
  output logic [PREG_W-1:0]    alloc_preg_2,
  output logic                 alloc_gnt,
  output logic                 stall,
  input  logic [NUM_PREGS-1:0] free_regs_i,
  output logic [PREG_W:0]      free_cnt,
  output logic                 release_err
);

  localparam int unsigned CNT_W = PREG_W + 1;
  localparam logic [NUM_PREGS-1:0] RESET_MAP = {NUM_PREGS{1'b1}} << NUM_AREGS;

  logic [NUM_PREGS-1:0] free_map;
  logic [NUM_PREGS-1:0] grant_mask;
  logic [NUM_PREGS-1:0] rel_mask;
  logic [NUM_PREGS-1:0] kept_map;
  logic [NUM_PREGS-1:0] newly_freed;
  logic [NUM_PREGS-1:0] free_map_next;
  logic [CNT_W-1:0]     rel_cnt;
  logic [CNT_W-1:0]     gnt_cnt;
  logic [CNT_W-1:0]     free_cnt_next;
  logic [1:0]           need;
  logic                 found_1;
  logic                 found_2;
  logic                 double_free;

  // Two-deep priority encode of the registered bitmap; absent entries read as 0.
  always_comb begin
    alloc_preg_1 = '0;
    alloc_preg_2 = '0;
    found_1      = 1'b0;
    found_2      = 1'b0;
    for (int unsigned i = 0; i < NUM_PREGS; i++) begin
      if (free_map[i]) begin
        if (!found_1) begin
          alloc_preg_1 = PREG_W'(i);
          found_1      = 1'b1;
        end else if (!found_2) begin
          alloc_preg_2 = PREG_W'(i);
          found_2      = 1'b1;
        end
      end
    end
  end

  // All-or-nothing grant against the registered count.
  always_comb begin
    need      = alloc_req_1 ? (alloc_req_2 ? 2'd2 : 2'd1) : 2'd0;
    alloc_gnt = (need != 2'd0) && (free_cnt >= CNT_W'(need));
    stall     = (need != 2'd0) && !alloc_gnt;
  end

  // Next state: consume granted bits, then releases win; p0 is never released.
  always_comb begin
    grant_mask = '0;
    if (alloc_gnt) begin
      grant_mask[alloc_preg_1] = 1'b1;
      if (need == 2'd2) grant_mask[alloc_preg_2] = 1'b1;
    end
    rel_mask      = {free_regs_i[NUM_PREGS-1:1], 1'b0};
    kept_map      = free_map & ~grant_mask;
    newly_freed   = rel_mask & ~kept_map;
    free_map_next = kept_map | rel_mask;
    double_free   = |(rel_mask & free_map);
    rel_cnt       = '0;
    for (int unsigned i = 0; i < NUM_PREGS; i++) begin
      rel_cnt = rel_cnt + CNT_W'(newly_freed[i]);
    end
    gnt_cnt       = alloc_gnt ? CNT_W'(need) : '0;
    free_cnt_next = free_cnt - gnt_cnt + rel_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_map    <= RESET_MAP;
      free_cnt    <= CNT_W'(NUM_PREGS - NUM_AREGS);
      release_err <= 1'b0;
    end else begin
      free_map    <= free_map_next;
      free_cnt    <= free_cnt_next;
      release_err <= release_err | double_free;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: vector table, directed corner sequences and
// randomized traffic checked against a free-flag array model.
module tb_phys_reg_free_list;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_req_1, alloc_req_2;
  logic [5:0]  alloc_preg_1, alloc_preg_2;
  logic        alloc_gnt, stall;
  logic [63:0] free_regs_i;
  logic [6:0]  free_cnt;
  logic        release_err;

  int checks = 0;
  int errors = 0;

  bit mfree[64];
  bit merr;

  typedef struct {
    logic        r1;
    logic        r2;
    logic [63:0] mask;
    int          p1;
    int          p2;
    logic        gnt;
    logic        stall;
    int          cnt;
  } vec_t;

  vec_t tab[8];

  phys_reg_free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req_1  (alloc_req_1),
    .alloc_req_2  (alloc_req_2),
    .alloc_preg_1 (alloc_preg_1),
    .alloc_preg_2 (alloc_preg_2),
    .alloc_gnt    (alloc_gnt),
    .stall        (stall),
    .free_regs_i  (free_regs_i),
    .free_cnt     (free_cnt),
    .release_err  (release_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int count_free();
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(mfree[i]);
    return n;
  endfunction

  // Index of the k-th (0-based) lowest free register, 0 if none.
  function automatic int nth_free(input int k);
    int seen = 0;
    for (int i = 0; i < 64; i++) begin
      if (mfree[i]) begin
        if (seen == k) return i;
        seen++;
      end
    end
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) mfree[i] = (i >= 32);
    merr = 1'b0;
  endfunction

  // One clock: drive, sample at negedge against model, advance model at posedge.
  task automatic cycle(input logic r1, input logic r2, input logic [63:0] m,
                       output int s_p1, output int s_p2, output int s_cnt,
                       output logic s_gnt, output logic s_stall);
    int  need;
    bit  egnt;
    int  a, b;
    bit  pre[64];
    alloc_req_1 = r1;
    alloc_req_2 = r2;
    free_regs_i = m;
    @(negedge clk);
    s_p1 = int'(alloc_preg_1);
    s_p2 = int'(alloc_preg_2);
    s_cnt = int'(free_cnt);
    s_gnt = alloc_gnt;
    s_stall = stall;
    need = r1 ? (r2 ? 2 : 1) : 0;
    egnt = (need > 0) && (count_free() >= need);
    a = nth_free(0);
    b = nth_free(1);
    chk("alloc_preg_1", s_p1, a);
    chk("alloc_preg_2", s_p2, b);
    chk("free_cnt", s_cnt, count_free());
    chk("alloc_gnt", s_gnt, egnt);
    chk("stall", s_stall, (need > 0) && !egnt);
    chk("release_err", release_err, merr);
    @(posedge clk);
    pre = mfree;
    if (egnt) begin
      mfree[a] = 1'b0;
      if (need == 2) mfree[b] = 1'b0;
    end
    for (int i = 1; i < 64; i++) begin
      if (m[i]) begin
        if (pre[i]) merr = 1'b1;
        mfree[i] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic step(input logic r1, input logic r2, input logic [63:0] m);
    int p1, p2, c;
    logic g, s;
    cycle(r1, r2, m, p1, p2, c, g, s);
  endtask

  task automatic do_reset();
    alloc_req_1 = 1'b0;
    alloc_req_2 = 1'b0;
    free_regs_i = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p1, p2, c;
    logic g, s;
    logic [63:0] m;

    tab[0] = '{1'b0, 1'b0, 64'd0,    32, 33, 1'b0, 1'b0, 32};
    tab[1] = '{1'b1, 1'b0, 64'd0,    32, 33, 1'b1, 1'b0, 32};
    tab[2] = '{1'b1, 1'b0, 64'd0,    33, 34, 1'b1, 1'b0, 31};
    tab[3] = '{1'b1, 1'b0, 64'd0,    34, 35, 1'b1, 1'b0, 30};
    tab[4] = '{1'b0, 1'b0, 64'd1,    35, 36, 1'b0, 1'b0, 29};
    tab[5] = '{1'b0, 1'b1, 64'd0,    35, 36, 1'b0, 1'b0, 29};
    tab[6] = '{1'b1, 1'b1, 64'd0,    35, 36, 1'b1, 1'b0, 29};
    tab[7] = '{1'b0, 1'b0, 64'd0,    37, 38, 1'b0, 1'b0, 27};

    do_reset();
    chk("reset release_err", release_err, 0);

    for (int i = 0; i < 8; i++) begin
      cycle(tab[i].r1, tab[i].r2, tab[i].mask, p1, p2, c, g, s);
      chk($sformatf("tab%0d p1", i), p1, tab[i].p1);
      chk($sformatf("tab%0d p2", i), p2, tab[i].p2);
      chk($sformatf("tab%0d gnt", i), g, tab[i].gnt);
      chk($sformatf("tab%0d stall", i), s, tab[i].stall);
      chk($sformatf("tab%0d cnt", i), c, tab[i].cnt);
    end

    // Drain p37..p62 with dual grants, leaving only p63.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b1, '0);
    cycle(1'b1, 1'b1, '0, p1, p2, c, g, s);
    chk("starve dual stall", s, 1);
    chk("starve dual cnt", c, 1);
    chk("starve dual p1", p1, 63);
    cycle(1'b1, 1'b0, '0, p1, p2, c, g, s);
    chk("starve single gnt", g, 1);
    chk("starve single p1", p1, 63);
    cycle(1'b1, 1'b0, '0, p1, p2, c, g, s);
    chk("empty cnt", c, 0);
    chk("empty stall", s, 1);
    chk("empty p1", p1, 0);
    chk("empty p2", p2, 0);

    // Release and dual request in the same cycle: no bypass.
    m = 64'd1 << 40;
    step(1'b0, 1'b0, m);
    m = 64'd1 << 5;
    cycle(1'b1, 1'b1, m, p1, p2, c, g, s);
    chk("relalloc stall", s, 1);
    chk("relalloc cnt", c, 1);
    cycle(1'b1, 1'b1, '0, p1, p2, c, g, s);
    chk("relalloc next cnt", c, 2);
    chk("relalloc next p1", p1, 5);
    chk("relalloc next p2", p2, 40);
    chk("relalloc next gnt", g, 1);
    cycle(1'b0, 1'b0, '0, p1, p2, c, g, s);
    chk("relalloc drained", c, 0);

    // Double free, p0 release, and grant colliding with release.
    m = 64'd1 << 33;
    step(1'b0, 1'b0, m);
    cycle(1'b0, 1'b0, m, p1, p2, c, g, s);
    chk("first release cnt", c, 1);
    cycle(1'b0, 1'b0, 64'd1, p1, p2, c, g, s);
    chk("double free err", release_err, 1);
    chk("double free cnt", c, 1);
    cycle(1'b1, 1'b0, m, p1, p2, c, g, s);
    chk("p0 ignored cnt", c, 1);
    chk("collide gnt p1", p1, 33);
    cycle(1'b0, 1'b0, '0, p1, p2, c, g, s);
    chk("collide cnt", c, 1);
    chk("collide p1", p1, 33);

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    chk("async rst free_cnt", free_cnt, 32);
    chk("async rst err", release_err, 0);
    chk("async rst p1", alloc_preg_1, 32);
    chk("async rst p2", alloc_preg_2, 33);
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (n % 750 == 749) do_reset();
      m = '0;
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 1) == 0) m[$urandom_range(1, 63)] = 1'b1;
      if ($urandom_range(0, 15) == 0) m[0] = 1'b1;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Physical-register free list between rename/dispatch and the reorder buffer.
- Every cycle it supplies up to two free physical destination registers to rename, which turns them into curr_dest_reg for new ROB entries.
- It absorbs the one-hot free mask the ROB emits at retirement, returning old destination registers to the pool.
- State is a NUM_PREGS-bit free bitmap plus a registered free counter.

Parameters:
NUM_PREGS, 64, number of physical registers; bitmap width.
NUM_AREGS, 32, architectural registers; p0..p(NUM_AREGS-1) are mapped at reset.
PREG_W, 6, physical register index width, log2(NUM_PREGS).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  reset; asynchronous, active-low.
alloc_req_1  input  1  rename needs one destination register this cycle.
alloc_req_2  input  1  rename needs a second destination register; only meaningful with alloc_req_1.
alloc_preg_1  output  PREG_W  lowest-index free register (combinational from bitmap).
alloc_preg_2  output  PREG_W  second-lowest-index free register (combinational).
alloc_gnt  output  1  request accepted this cycle; the registers shown are consumed at posedge.
stall  output  1  request present but insufficient free registers; rename must hold.
free_regs_i  input  NUM_PREGS  release mask from ROB retirement; bit n set frees pn.
free_cnt  output  PREG_W+1  registered count of free registers (0..NUM_PREGS-1).
release_err  output  1  sticky error: a released register was already free.

Behaviour:
- Reset (rst_n low, asynchronous):
  - bitmap bits 0..NUM_AREGS-1 = 0 (in use); bits NUM_AREGS..NUM_PREGS-1 = 1 (free).
  - free_cnt = NUM_PREGS-NUM_AREGS (32); release_err = 0.
  - Combinational outputs then settle to alloc_preg_1=32, alloc_preg_2=33, alloc_gnt=0, stall=0.
- p0 is reserved for x0:
  - bitmap bit 0 is never set.
  - free_regs_i[0] is ignored, counted neither in free_cnt nor in release_err.
- Request decode:
  - need = 0 if !alloc_req_1; 1 if alloc_req_1 & !alloc_req_2; 2 if both.
  - alloc_req_2 without alloc_req_1 is treated as need=0.
- Grant rule (combinational, all-or-nothing):
  - alloc_gnt = (need>0) & (free_cnt >= need).
  - stall = (need>0) & !alloc_gnt.
  - Example: need=2 with one free register means no grant, nothing consumed, stall=1.
- Register selection:
  - Priority encode the current registered bitmap only.
  - Registers freed in the same cycle are not visible until the next cycle; there is no bypass.
  - alloc_preg_1/2 must be valid whenever free_cnt >= 1 / >= 2.
  - When no such register exists, drive the output to 0.
- Posedge update, in this order:
  1. Clear the bitmap bits of granted registers (alloc_preg_1, plus alloc_preg_2 if need=2).
  2. OR in free_regs_i[NUM_PREGS-1:1].
  3. free_cnt_next = free_cnt - (gnt ? need : 0) + popcount(newly freed bits).
- Double free:
  - If any free_regs_i bit n>0 is already set in the registered bitmap, set release_err (sticky until reset).
  - That bit stays 1 and is not counted again.
- Simultaneous events:
  - A granted register cannot also be in free_regs_i unless the design is broken.
  - If it happens, the release wins (bit ends at 1), it is counted as freed, and release_err is set.
- Width rule:
  - free_cnt never exceeds NUM_PREGS-1 and never underflows.
  - The bench asserts free_cnt == popcount(bitmap) every cycle.
- Full/empty:
  - free_cnt==0: any request stalls.
  - free_cnt==NUM_PREGS-1: every register except p0 is free; a release here is necessarily a double free.
- Reset mid-operation: the bitmap and counter revert immediately to reset values; in-flight grants are lost.

Test Plan:
- Reset then idle: free_cnt=32, alloc_preg_1=32, alloc_preg_2=33, stall=0, release_err=0.
- Single allocation (alloc_req_1=1 for 3 cycles): grants p32, p33, p34 in order; free_cnt 32 -> 29.
- Drain with dual requests:
  - 16 dual-allocation cycles exhaust p32..p63; free_cnt=0.
  - The 17th request gives stall=1, alloc_gnt=0, and bitmap unchanged.
- Partial starvation: with free_cnt=1 (only p63), a dual request gives stall=1 and no consumption; a single request next cycle grants p63 and free_cnt=0.
- Release plus allocation in the same cycle:
  - Setup: p40 free, free_cnt=1; dual request while free_regs_i has bit 5 set.
  - Result: stall=1, and next cycle p5 is free and free_cnt=2.
  - Next dual request then grants p5 and p40.
- Errors and p0:
  - Releasing p33 while already free sets release_err=1 and leaves free_cnt unchanged.
  - free_regs_i[0]=1 changes nothing.
  - Asserting rst_n low mid-stream restores free_cnt=32 and release_err=0 asynchronously.
